// File: rtl/branch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : branch_pc_sequencer
// Description : Multicycle PC sequencer. Accepts one instruction (op, imm16,
//               jidx26) from the control FSM and walks it through
//               IDLE -> LATCH -> TARGET -> EVAL. In EVAL it resolves the
//               branch using the zero-detect flag and writes the new PC.
//               It also keeps a saturating count of taken BEQ/BNE branches.
//
// Ports       : clk          rising-edge clock
//               rst_n        asynchronous active-low reset
//               start        begin one instruction (IDLE, stall=0 only)
//               op           00 SEQ, 01 BEQ, 10 BNE, 11 JUMP
//               imm16        signed word offset for BEQ/BNE
//               jidx26       jump word index
//               branch       1 = ALU result nonzero, sampled in EVAL
//               stall        freezes LATCH/TARGET/EVAL, blocks start in IDLE
//               pc           current program counter (registered)
//               pc_write     one-cycle pulse when pc is updated
//               done         one-cycle pulse, coincident with pc_write
//               busy         high in every state except IDLE
//               taken        decision of the last completed instruction
//               taken_count  saturating count of taken BEQ/BNE
//
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TAKEN_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [15:0]            imm16,
    input  logic [25:0]            jidx26,
    input  logic                   branch,
    input  logic                   stall,
    output logic [31:0]            pc,
    output logic                   pc_write,
    output logic                   done,
    output logic                   busy,
    output logic                   taken,
    output logic [TAKEN_CNT_W-1:0] taken_count
);

    // State encoding
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LATCH  = 2'd1;
    localparam logic [1:0] c_TARGET = 2'd2;
    localparam logic [1:0] c_EVAL   = 2'd3;

    // Opcode encoding
    localparam logic [1:0] c_OP_SEQ  = 2'b00;
    localparam logic [1:0] c_OP_BEQ  = 2'b01;
    localparam logic [1:0] c_OP_BNE  = 2'b10;
    localparam logic [1:0] c_OP_JUMP = 2'b11;

    localparam logic [TAKEN_CNT_W-1:0] c_CNT_ONE = TAKEN_CNT_W'(1);

    logic [1:0]             r_state;
    logic [1:0]             r_op;
    logic [15:0]            r_imm16;
    logic [25:0]            r_jidx26;
    logic [31:0]            r_pc4;
    logic [31:0]            r_btgt;
    logic [31:0]            r_jtgt;
    logic [31:0]            r_pc;
    logic                   r_pc_write;
    logic                   r_done;
    logic                   r_busy;
    logic                   r_taken;
    logic [TAKEN_CNT_W-1:0] r_taken_count;

    logic [31:0]            w_next_pc;
    logic                   w_taken;
    logic                   w_cond_taken;

    // Branch resolution from the targets prepared in LATCH/TARGET.
    // w_cond_taken isolates the conditional branches so JUMP never
    // advances the debug counter.
    always_comb begin
        w_next_pc    = r_pc4;
        w_taken      = 1'b0;
        w_cond_taken = 1'b0;
        case (r_op)
            c_OP_SEQ: begin
                w_next_pc = r_pc4;
                w_taken   = 1'b0;
            end
            c_OP_BEQ: begin
                w_cond_taken = ~branch;
                w_taken      = w_cond_taken;
                w_next_pc    = w_cond_taken ? r_btgt : r_pc4;
            end
            c_OP_BNE: begin
                w_cond_taken = branch;
                w_taken      = w_cond_taken;
                w_next_pc    = w_cond_taken ? r_btgt : r_pc4;
            end
            c_OP_JUMP: begin
                w_next_pc = r_jtgt;
                w_taken   = 1'b1;
            end
            default: begin
                w_next_pc = r_pc4;
                w_taken   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_op          <= c_OP_SEQ;
            r_imm16       <= 16'h0000;
            r_jidx26      <= 26'h000_0000;
            r_pc4         <= 32'h0000_0000;
            r_btgt        <= 32'h0000_0000;
            r_jtgt        <= 32'h0000_0000;
            r_pc          <= RESET_PC;
            r_pc_write    <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_taken       <= 1'b0;
            r_taken_count <= '0;
        end else begin
            // Completion strobes are single-cycle unless re-armed in EVAL.
            r_pc_write <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start && !stall) begin
                        r_op     <= op;
                        r_imm16  <= imm16;
                        r_jidx26 <= jidx26;
                        r_busy   <= 1'b1;
                        r_state  <= c_LATCH;
                    end
                end
                c_LATCH: begin
                    if (!stall) begin
                        r_pc4   <= r_pc + 32'd4;
                        r_state <= c_TARGET;
                    end
                end
                c_TARGET: begin
                    if (!stall) begin
                        // Word offset -> byte offset: sign-extend, then << 2.
                        r_btgt  <= r_pc4 + {{14{r_imm16[15]}}, r_imm16, 2'b00};
                        r_jtgt  <= {r_pc4[31:28], r_jidx26, 2'b00};
                        r_state <= c_EVAL;
                    end
                end
                c_EVAL: begin
                    if (!stall) begin
                        r_pc       <= w_next_pc;
                        r_taken    <= w_taken;
                        r_pc_write <= 1'b1;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= c_IDLE;
                        if (w_cond_taken && !(&r_taken_count)) begin
                            r_taken_count <= r_taken_count + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign pc_write    = r_pc_write;
    assign done        = r_done;
    assign busy        = r_busy;
    assign taken       = r_taken;
    assign taken_count = r_taken_count;

endmodule
`default_nettype wire
